// File: rtl/cache_pkg.sv
// Cache/bus shared definitions.
//   BLK_WORDS   : words per dcache block (two-beat block transfers).
//   bus_state_t : coherence bus controller FSM states.
package cache_pkg;
    localparam int BLK_WORDS = 2;

    // Beat index within a dcache block.
    typedef logic [$clog2(BLK_WORDS)-1:0] beat_t;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        IFETCH = 4'd1,
        WB1    = 4'd2,
        WB2    = 4'd3,
        SNOOP  = 4'd4,
        XFER1  = 4'd5,
        XFER2  = 4'd6,
        FILL1  = 4'd7,
        FILL2  = 4'd8
    } bus_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types.
//   word_t     : 32-bit memory word.
//   ramstate_t : handshake status reported by the single-ported RAM.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

// File: rtl/bus_arbiter.sv
// Two-core request arbiter for the coherence bus.
// Config macro: BUS_RR_EN -- when defined, round-robin with a pointer
// register; otherwise fixed priority (core 0 wins ties, no state).
// Ports:
//   req    : per-core request vector for the class being arbitrated.
//   gnt    : one-hot grant (all zero when nothing is requested).
//   CLK    : clock (round-robin build only).
//   nRST   : asynchronous active-low reset (round-robin build only).
//   upd    : a transaction has just completed (round-robin build only).
//   served : index of the core that transaction served (round-robin build only).
module bus_arbiter #(
    parameter int CPUS = 2
) (
    input  logic [CPUS-1:0] req,
    output logic [CPUS-1:0] gnt
`ifdef BUS_RR_EN
    ,
    input  logic            CLK,
    input  logic            nRST,
    input  logic            upd,
    input  logic            served
`endif
);

`ifdef BUS_RR_EN
    // ptr names the core that wins a tie.
    logic ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= 1'b0;
        end else if (upd) begin
            ptr <= ~served;
        end
    end

    always_comb begin
        gnt = '0;
        if (req[ptr]) begin
            gnt[ptr] = 1'b1;
        end else if (req[~ptr]) begin
            gnt[~ptr] = 1'b1;
        end
    end
`else
    always_comb begin
        gnt = '0;
        if (req[0]) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Coherence bus controller: arbitrates icache/dcache requests of two cores
// onto one single-ported RAM and sequences two-word dcache block fills,
// writebacks and snoop-driven cache-to-cache transfers.
// Config macro: BUS_RR_EN (round-robin arbitration; fixed priority otherwise).
// Ports:
//   CLK, nRST          : clock, asynchronous active-low reset.
//   iREN/iaddr         : icache read request + word address per core.
//   iwait/iload        : icache stall + read data per core.
//   dREN/dWEN/daddr    : dcache fill / writeback request + word address.
//   dstore             : writeback or snoop-supply data per core.
//   dwait/dload        : dcache stall + fill data per core.
//   ccwrite/cctrans    : requester-wants-exclusive / snooped-holds-Modified.
//   ccwait/ccinv       : snoop in progress / invalidate snooped block.
//   ccsnoopaddr        : address being snooped, per core.
//   ramREN/ramWEN      : RAM read / write strobes.
//   ramaddr/ramstore   : RAM address / write data.
//   ramload/ramstate   : RAM read data / RAM handshake status.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
    import cache_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CPUS-1:0] iREN,
    input  word_t           iaddr       [CPUS],
    output logic [CPUS-1:0] iwait,
    output word_t           iload       [CPUS],
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  word_t           daddr       [CPUS],
    input  word_t           dstore      [CPUS],
    output logic [CPUS-1:0] dwait,
    output word_t           dload       [CPUS],
    input  logic [CPUS-1:0] ccwrite,
    input  logic [CPUS-1:0] cctrans,
    output logic [CPUS-1:0] ccwait,
    output logic [CPUS-1:0] ccinv,
    output word_t           ccsnoopaddr [CPUS],
    output logic            ramREN,
    output logic            ramWEN,
    output word_t           ramaddr,
    output word_t           ramstore,
    input  word_t           ramload,
    input  ramstate_t       ramstate
);

    bus_state_t      state, state_nx;
    logic            gnt;      // latched granted core
    logic            oth;      // the other (snooped) core
    logic            gnt_idx;
    logic            acc;
    logic [CPUS-1:0] arb_req, arb_gnt;

    assign acc = (ramstate == ACCESS);
    assign oth = ~gnt;

    // Only the highest-priority non-empty class is offered to the arbiter.
    assign arb_req = (|dWEN) ? dWEN : (|dREN) ? dREN : iREN;

    always_comb begin
        gnt_idx = 1'b0;
        for (int i = 0; i < CPUS; i++) begin
            if (arb_gnt[i]) gnt_idx = 1'(i);
        end
    end

`ifdef BUS_RR_EN
    logic done;
    assign done = acc && (state == IFETCH || state == WB2 ||
                          state == XFER2  || state == FILL2);

    bus_arbiter #(.CPUS(CPUS)) u_arb (
        .req    (arb_req),
        .gnt    (arb_gnt),
        .CLK    (CLK),
        .nRST   (nRST),
        .upd    (done),
        .served (gnt)
    );
`else
    bus_arbiter #(.CPUS(CPUS)) u_arb (
        .req (arb_req),
        .gnt (arb_gnt)
    );
`endif

    // State register; grant is captured only when leaving IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            gnt   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx != IDLE) gnt <= gnt_idx;
        end
    end

    // Next state: any ramstate other than ACCESS (including ERROR) holds.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (|dWEN)      state_nx = WB1;
                else if (|dREN) state_nx = SNOOP;
                else if (|iREN) state_nx = IFETCH;
            end
            IFETCH:  if (acc) state_nx = IDLE;
            WB1:     if (acc) state_nx = WB2;
            WB2:     if (acc) state_nx = IDLE;
            SNOOP:   state_nx = cctrans[oth] ? XFER1 : FILL1;
            XFER1:   if (acc) state_nx = XFER2;
            XFER2:   if (acc) state_nx = IDLE;
            FILL1:   if (acc) state_nx = FILL2;
            FILL2:   if (acc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: Moore on state/gnt, except load data and the ACCESS wait release.
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        for (int i = 0; i < CPUS; i++) begin
            iload[i]       = '0;
            dload[i]       = '0;
            ccsnoopaddr[i] = '0;
        end
        case (state)
            IFETCH: begin
                ramREN     = 1'b1;
                ramaddr    = iaddr[gnt];
                iload[gnt] = ramload;
                if (acc) iwait[gnt] = 1'b0;
            end
            WB1, WB2: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[gnt];
                ramstore = dstore[gnt];
                if (acc) dwait[gnt] = 1'b0;
            end
            SNOOP: begin
                ccwait[oth]      = 1'b1;
                ccsnoopaddr[oth] = daddr[gnt];
                ccinv[oth]       = ccwrite[gnt];
            end
            // The Modified owner supplies the requester and memory at once.
            XFER1, XFER2: begin
                ccwait[oth]      = 1'b1;
                ccsnoopaddr[oth] = daddr[gnt];
                dload[gnt]       = dstore[oth];
                ramWEN           = 1'b1;
                ramaddr          = daddr[oth];
                ramstore         = dstore[oth];
                if (acc) dwait[gnt] = 1'b0;
            end
            FILL1, FILL2: begin
                ramREN     = 1'b1;
                ramaddr    = daddr[gnt];
                dload[gnt] = ramload;
                if (acc) dwait[gnt] = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: RAM model with programmable latency, a
// scoreboard of expected RAM words and a monitor popping it on each ACCESS.
module tb_coherence_bus_ctrl;
    import cpu_types_pkg::*;

    typedef struct {
        logic  ren;
        logic  wen;
        word_t addr;
        word_t store;
        int    core;
        logic  is_i;
        logic  chk_load;
        word_t load;
    } exp_t;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [1:0] iREN = '0, dREN = '0, dWEN = '0, ccwrite = '0, cctrans = '0;
    logic [1:0] iwait, dwait, ccwait, ccinv;
    word_t      iaddr [2], daddr [2], dstore [2];
    word_t      iload [2], dload [2], ccsnoopaddr [2];
    logic       ramREN, ramWEN;
    word_t      ramaddr, ramstore, ramload;
    ramstate_t  ramstate = FREE;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   lat = 2;
    int   cnt = 0;
    logic err_first = 1'b0;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    function automatic word_t ram_data(word_t a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], 16'hA5A5};
    endfunction

    assign ramload = (ramstate == ACCESS && ramREN) ? ram_data(ramaddr) : 32'h0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // RAM model (drives ramstate) followed by the scoreboard monitor.
    always @(negedge CLK) begin
        logic [1:0] wm;
        exp_t e;
        if (!nRST) begin
            ramstate = FREE;
            cnt = 0;
        end else if ((ramREN || ramWEN) && ramstate != ACCESS) begin
            if (cnt >= lat) begin
                ramstate = ACCESS;
                cnt = 0;
            end else begin
                ramstate = (err_first && cnt == 0) ? ERROR : BUSY;
                cnt++;
            end
        end else begin
            ramstate = FREE;
            cnt = 0;
        end
        #1;
        if (ramstate == ACCESS && (ramREN || ramWEN)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access addr=%h ren=%b wen=%b", ramaddr, ramREN, ramWEN);
            end else begin
                e = sb.pop_front();
                chk("ram_ctl", {30'd0, ramREN, ramWEN}, {30'd0, e.ren, e.wen});
                chk("ram_addr", ramaddr, e.addr);
                if (e.wen) chk("ram_store", ramstore, e.store);
                wm = 2'b11;
                wm[e.core] = 1'b0;
                chk("iwait", {30'd0, iwait}, {30'd0, (e.is_i ? wm : 2'b11)});
                chk("dwait", {30'd0, dwait}, {30'd0, (e.is_i ? 2'b11 : wm)});
                if (e.chk_load)
                    chk(e.is_i ? "iload" : "dload", e.is_i ? iload[e.core] : dload[e.core], e.load);
            end
        end
    end

    task automatic push(logic ren, logic wen, word_t a, word_t st, int c,
                        logic is_i, logic cl, word_t ld);
        exp_t e;
        e.ren = ren; e.wen = wen; e.addr = a; e.store = st; e.core = c;
        e.is_i = is_i; e.chk_load = cl; e.load = ld;
        sb.push_back(e);
    endtask

    // Wait (bounded) until at most n expected words remain outstanding.
    task automatic wait_q(int n, string nm);
        int k = 0;
        while (sb.size() > n && k < 50) begin
            @(negedge CLK); #2;
            k++;
        end
        checks++;
        if (sb.size() > n) begin
            errors++;
            $display("FAIL %s_timeout outstanding=%0d required=%0d", nm, sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic snoop_chk(logic inv, word_t a, string nm);
        int k = 0;
        while (!ccwait[1] && k < 20) begin
            @(negedge CLK); #2;
            k++;
        end
        chk({nm, "_ccwait"}, {30'd0, ccwait}, 32'd2);
        chk({nm, "_ccinv"}, {31'd0, ccinv[1]}, {31'd0, inv});
        chk({nm, "_snoopaddr"}, ccsnoopaddr[1], a);
        chk({nm, "_ram_idle"}, {30'd0, ramREN, ramWEN}, 32'd0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        #2 nRST = 1'b1;
    endtask

    initial begin
        word_t cur [2];
        int c;
        for (int i = 0; i < 2; i++) begin
            iaddr[i] = '0; daddr[i] = '0; dstore[i] = '0;
        end
        repeat (2) @(negedge CLK);
        #2;
        // Reset state
        chk("rst_iwait", {30'd0, iwait}, 32'd3);
        chk("rst_dwait", {30'd0, dwait}, 32'd3);
        chk("rst_cc", {28'd0, ccwait, ccinv}, 32'd0);
        chk("rst_ram", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        nRST = 1'b1;
        @(negedge CLK); #2;

        // icache fetch with two BUSY cycles
        lat = 2;
        iaddr[0] = 32'h100; iREN[0] = 1'b1;
        push(1, 0, 32'h100, 0, 0, 1, 1, 32'hDEADBEEF);
        wait_q(0, "ifetch");
        iREN[0] = 1'b0;
        @(negedge CLK); #2;
        chk("ifetch_idle", {29'd0, ramREN, iwait}, 32'd3);

        // core 1 two-word writeback
        lat = 1;
        daddr[1] = 32'h200; dstore[1] = 32'h11; dWEN[1] = 1'b1;
        push(0, 1, 32'h200, 32'h11, 1, 0, 0, 0);
        push(0, 1, 32'h204, 32'h22, 1, 0, 0, 0);
        wait_q(1, "wb1");
        daddr[1] = 32'h204; dstore[1] = 32'h22;
        wait_q(0, "wb2");
        dWEN[1] = 1'b0;
        @(negedge CLK); #2;

        // cache-to-cache transfer from Modified core 1
        daddr[0] = 32'h300; ccwrite[0] = 1'b1;
        daddr[1] = 32'h300; dstore[1] = 32'hAA; cctrans[1] = 1'b1;
        dREN[0] = 1'b1;
        push(0, 1, 32'h300, 32'hAA, 0, 0, 1, 32'hAA);
        push(0, 1, 32'h304, 32'hBB, 0, 0, 1, 32'hBB);
        snoop_chk(1'b1, 32'h300, "xfer");
        wait_q(1, "xfer1");
        daddr[0] = 32'h304; daddr[1] = 32'h304; dstore[1] = 32'hBB;
        wait_q(0, "xfer2");
        dREN[0] = 1'b0; ccwrite[0] = 1'b0; cctrans[1] = 1'b0;
        @(negedge CLK); #2;

        // fill from RAM; ERROR cycles must behave like BUSY
        lat = 2; err_first = 1'b1;
        daddr[0] = 32'h400; dREN[0] = 1'b1;
        push(1, 0, 32'h400, 0, 0, 0, 1, 32'h0400A5A5);
        push(1, 0, 32'h404, 0, 0, 0, 1, 32'h0404A5A5);
        snoop_chk(1'b0, 32'h400, "fill");
        wait_q(1, "fill1");
        daddr[0] = 32'h404;
        wait_q(0, "fill2");
        dREN[0] = 1'b0; err_first = 1'b0;
        @(negedge CLK); #2;

        // both cores fetching continuously
        do_reset();
        lat = 1;
        cur[0] = 32'h1000; cur[1] = 32'h1100;
        iaddr[0] = cur[0]; iaddr[1] = cur[1];
        iREN = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef BUS_RR_EN
            c = k % 2;
`else
            c = 0;
`endif
            push(1, 0, cur[c], 0, c, 1, 1, ram_data(cur[c]));
            wait_q(0, "arb");
            cur[c] = cur[c] + 32'd4;
            iaddr[c] = cur[c];
        end
        iREN = 2'b00;
        @(negedge CLK); #2;

        // writeback beats icache; reset mid-WB2 aborts
        do_reset();
        lat = 1;
        daddr[0] = 32'h500; dstore[0] = 32'h55;
        iREN = 2'b11; dWEN[0] = 1'b1;
        push(0, 1, 32'h500, 32'h55, 0, 0, 0, 0);
        wait_q(0, "prio_wb1");
        daddr[0] = 32'h504; dstore[0] = 32'h66; lat = 4;
        @(negedge CLK); #2;
        chk("wb2_active", {31'd0, ramWEN}, 32'd1);
        chk("wb2_addr", ramaddr, 32'h504);
        nRST = 1'b0;
        #1;
        chk("abort_waits", {28'd0, iwait, dwait}, 32'hF);
        chk("abort_ram", {30'd0, ramREN, ramWEN}, 32'd0);
        iREN = 2'b00; dWEN = 2'b00;
        @(negedge CLK); #2;
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Shared memory/coherence controller for a dual-core pipeline.
- Arbitrates icache and dcache requests from CPUS cores onto one single-ported RAM.
- Sequences two-word dcache block transfers: fills, dirty writebacks, and snoop-driven cache-to-cache transfers.
- Sits between the per-core caches (whose dcache FSM includes SNOOPING/DATA_XFER states) and the RAM.

Parameters:
- CPUS, 2, number of cores; only 2 supported.
- BLK_WORDS, 2, words per dcache block; fixed at 2.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  [CPUS]  icache read request.
- iaddr  in  [CPUS]x32  icache word address.
- iwait  out  [CPUS]  1 = icache request not yet served.
- iload  out  [CPUS]x32  icache read data.
- dREN  in  [CPUS]  dcache fill request (word address on daddr).
- dWEN  in  [CPUS]  dcache writeback request.
- daddr  in  [CPUS]x32  dcache word address.
- dstore  in  [CPUS]x32  writeback or snoop-supply data.
- dwait  out  [CPUS]  1 = dcache word not yet served.
- dload  out  [CPUS]x32  dcache fill data.
- ccwrite  in  [CPUS]  requester intends to write (fill for exclusive).
- cctrans  in  [CPUS]  snooped cache holds the block Modified and will supply it.
- ccwait  out  [CPUS]  snoop in progress; target cache enters SNOOPING.
- ccinv  out  [CPUS]  invalidate snooped block.
- ccsnoopaddr  out  [CPUS]x32  address being snooped.
- ramREN  out  1  RAM read.
- ramWEN  out  1  RAM write.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset: state IDLE; arbiter pointer = core 0; all wait outputs 1; ccwait, ccinv, ramREN, ramWEN = 0; addr/data outputs 0. Reset mid-transaction aborts immediately; no RAM write is completed.
- Outputs are Moore from state + granted core (gnt). Exceptions: dload/iload pass ramload combinationally, and wait deasserts in the cycle ramstate==ACCESS.
- A word completes when ramstate==ACCESS. Any other ramstate holds the current state. ERROR is treated as BUSY.
- Priority each IDLE cycle: dWEN > dREN > iREN. Within a class, the core is chosen by the arbiter. gnt is latched on leaving IDLE.
- FSM states: IDLE, IFETCH, WB1, WB2, SNOOP, XFER1, XFER2, FILL1, FILL2.
- IDLE -> WB1 on dWEN. -> SNOOP on dREN. -> IFETCH on iREN. Otherwise stays.
- IFETCH: ramREN=1, ramaddr=iaddr[gnt]. On ACCESS: iwait[gnt]=0, go to IDLE.
- WB1/WB2: ramWEN=1, ramaddr=daddr[gnt], ramstore=dstore[gnt]. Cache presents word0 then word1. ACCESS advances WB1->WB2->IDLE, with dwait[gnt]=0 per word.
- SNOOP: one cycle. With o = other core: ccwait[o]=1, ccsnoopaddr[o]=daddr[gnt], ccinv[o]=ccwrite[gnt]. Next: cctrans[o] ? XFER1 : FILL1.
- XFER1/XFER2: ccwait[o] held. dload[gnt]=dstore[o]. Simultaneously ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o] (memory updated). On ACCESS, dwait[gnt]=0 and advance; XFER2 -> IDLE.
- FILL1/FILL2: ramREN=1, ramaddr=daddr[gnt], dload[gnt]=ramload. ACCESS advances; FILL2 -> IDLE.
- After any completed transaction the arbiter updates (see Optional Feature).
- Simultaneous requests from both cores in the same class: only the granted core is served. The loser keeps wait=1 with no RAM activity on its behalf.
- A dWEN from the snooped core during SNOOP/XFER is ignored until IDLE.
- Word addresses are passed through unmodified. Block alignment is the cache's responsibility.

Optional Feature:
- Macro: BUS_RR_EN.
- Defined: round-robin. The pointer moves to the core after the one just served; ties are resolved from the pointer.
- Undefined: fixed priority, core 0 always wins ties; pointer logic absent.

Decomposition:
- In cache_pkg: bus_state_t (4-bit enum of the nine states) and constant BLK_WORDS.
- ramstate_t and word_t come from cpu_types_pkg.
- Sub-module bus_arbiter: CPUS-bit request vector in, one-hot grant out, plus pointer register (only under BUS_RR_EN).

Test Plan:
- Reset then core0 iREN, iaddr=0x100; RAM returns 0xDEADBEEF after 2 BUSY cycles -> ramREN with ramaddr=0x100 for 3 cycles; iload[0]=0xDEADBEEF and iwait[0]=0 in cycle 3; state back to IDLE.
- Core1 dWEN at daddr 0x200/0x204 with data 0x11/0x22 -> two RAM writes in order; dwait[1] low once per word.
- Core0 dREN at 0x300 with ccwrite=1; core1 cctrans=1 with dstore 0xAA, 0xBB -> ccwait[1]=1, ccinv[1]=1, ccsnoopaddr[1]=0x300; dload[0]=0xAA then 0xBB; RAM written with same values.
- Core0 dREN at 0x400, cctrans[1]=0 -> FILL from RAM; ccinv[1]=0.
- Both cores assert iREN repeatedly -> with BUS_RR_EN grants alternate 0,1,0,1; without it core 0 is always served first.
- Both cores assert iREN and core0 asserts dWEN in the same cycle -> writeback served first; reset asserted mid-WB2 -> all waits 1 and ramWEN 0 immediately.
